// File: rtl/gate2_pkg.sv
// Shared definitions for the 2-input gate tester: FSM state encoding,
// reference truth tables and the settle counter width.
package gate2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Truth tables indexed by {a,b}: bit i is the expected output for {a,b}=i.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  // Wait counter must reach SETTLE+1 with SETTLE up to 15.
  localparam int CNT_W = 5;

endpackage

// File: rtl/gate2_tester_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  // Two back-to-back flops; only the second one is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make ff2_q take the old ff1_q,
      // giving two real stages; blocking here would collapse them into one.
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/gate2_tester.sv
// Self-test driver/checker for a 2-input logic gate. Walks {a,b} through
// 00,01,10,11, waits for the gate output to settle and pass the
// synchroniser, compares it against TRUTH and reports per-vector errors.
module gate2_tester
  import gate2_pkg::*;
#(
  parameter logic [3:0]  TRUTH  = TT_AND,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec
);

  // WAIT covers SETTLE cycles of settling plus two synchroniser cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE + 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             pass_q,  pass_d;
  logic [3:0]       err_q,   err_d;

  logic             y_sync;
  logic             mismatch;

  sync2 u_sync_y (
    .clk (clk),
    .rst (rst),
    .d_i (y),
    .q_o (y_sync)
  );

  assign mismatch = (y_sync != TRUTH[idx_q]);

  // State register and all datapath registers; reset aborts any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates for the four-vector walk.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = 2'd0;
          cnt_d   = '0;
          err_d   = 4'b0000;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        err_d[idx_q] = err_q[idx_q] | mismatch;
        cnt_d        = '0;
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        // err_q already holds the final SAMPLE update here.
        pass_d  = (err_q == 4'b0000);
        busy_d  = 1'b0;
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // {a,b} tracks the vector index, which is zero whenever the tester is idle.
  assign a       = idx_q[1];
  assign b       = idx_q[0];
  assign busy    = busy_q;
  assign done    = (state_q == ST_DONE);
  assign pass    = pass_q;
  assign err_vec = err_q;

endmodule

// File: tb/tb_gate2_tester.sv
// Bench for gate2_tester: two instances (AND and XOR truth tables) driven
// side by side against a behavioural gate model whose function is selectable.
module tb_gate2_tester;
  import gate2_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  int         y_mode = 0;   // 0: AND gate, 1: tied 0, 2: tied 1, 3: XOR gate

  logic       a_and, b_and, y_and, busy_and, done_and, pass_and;
  logic [3:0] err_and;
  logic       a_xor, b_xor, y_xor, busy_xor, done_xor, pass_xor;
  logic [3:0] err_xor;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] err_and;
    logic [3:0] err_xor;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic gate_model(input int mode, input logic ga, input logic gb);
    case (mode)
      0:       return ga & gb;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ga ^ gb;
    endcase
  endfunction

  function automatic logic [3:0] exp_err(input logic [3:0] truth, input int mode);
    logic [3:0] e;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v    = 2'(i);
      e[i] = gate_model(mode, v[1], v[0]) ^ truth[i];
    end
    return e;
  endfunction

  assign y_and = gate_model(y_mode, a_and, b_and);
  assign y_xor = gate_model(y_mode, a_xor, b_xor);

  gate2_tester #(.TRUTH(TT_AND), .SETTLE(2)) dut_and (
    .clk(clk), .rst(rst), .start(start), .a(a_and), .b(b_and), .y(y_and),
    .busy(busy_and), .done(done_and), .pass(pass_and), .err_vec(err_and)
  );

  gate2_tester #(.TRUTH(TT_XOR), .SETTLE(2)) dut_xor (
    .clk(clk), .rst(rst), .start(start), .a(a_xor), .b(b_xor), .y(y_xor),
    .busy(busy_xor), .done(done_xor), .pass(pass_xor), .err_vec(err_xor)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full run: pulse start, watch 40 cycles, then score against the queue.
  task automatic do_run(input string tag, input int mode, input bit retrig);
    int   done_cnt_a = 0;
    int   done_cnt_x = 0;
    int   done_cyc   = -1;
    int   busy_cnt   = 0;
    int   ab_bad     = 0;
    exp_t e;

    y_mode = mode;
    sb_q.push_back('{err_and: exp_err(TT_AND, mode), err_xor: exp_err(TT_XOR, mode)});

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;   // accept edge just passed: this is cycle 0

    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 0) begin
        check({tag, "/cleared_err"},  32'(err_and), 32'h0);
        check({tag, "/cleared_pass"}, 32'(pass_and), 32'h0);
      end
      if (busy_and) busy_cnt++;
      if (cyc < 20 && {a_and, b_and} != 2'(cyc / 5)) ab_bad++;
      if (done_and) begin
        done_cnt_a++;
        done_cyc = cyc;
      end
      if (done_xor) done_cnt_x++;
      start = retrig && (cyc == 3 || cyc == 19);
      @(negedge clk);
    end
    start = 1'b0;

    check({tag, "/done_count"},     32'(done_cnt_a), 32'd1);
    check({tag, "/done_count_xor"}, 32'(done_cnt_x), 32'd1);
    check({tag, "/done_cycle"},     32'(done_cyc),   32'd20);
    check({tag, "/busy_cycles"},    32'(busy_cnt),   32'd21);
    check({tag, "/ab_sequence"},    32'(ab_bad),     32'd0);
    check({tag, "/idle_busy"},      32'(busy_and),   32'd0);
    check({tag, "/idle_ab"},        32'({a_and, b_and}), 32'd0);

    if (sb_q.size() == 0) begin
      check({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "/err_and"},  32'(err_and),  32'(e.err_and));
      check({tag, "/pass_and"}, 32'(pass_and), 32'(e.err_and == 4'b0000));
      check({tag, "/err_xor"},  32'(err_xor),  32'(e.err_xor));
      check({tag, "/pass_xor"}, 32'(pass_xor), 32'(e.err_xor == 4'b0000));
    end
  endtask

  // Reset asserted between clock edges partway through a run.
  task automatic reset_mid_run();
    int done_seen = 0;

    y_mode = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;   // cycle 0
    repeat (7) @(negedge clk);     // cycle 7: vector 01, vector 00 already failed
    check("rst_mid/pre_ab",  32'({a_and, b_and}), 32'd1);
    check("rst_mid/pre_err", 32'(err_and), 32'b0001);

    #2 rst = 1'b1;
    #1;
    check("rst_mid/ab",      32'({a_and, b_and}), 32'd0);
    check("rst_mid/busy",    32'(busy_and), 32'd0);
    check("rst_mid/err",     32'(err_and),  32'd0);
    check("rst_mid/pass",    32'(pass_and), 32'd0);
    check("rst_mid/done",    32'(done_and), 32'd0);
    check("rst_mid/err_xor", 32'(err_xor),  32'd0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_and || done_xor || busy_and) done_seen++;
    end
    check("rst_mid/no_done", 32'(done_seen), 32'd0);
  endtask

  initial begin
    #1;
    check("reset/ab",   32'({a_and, b_and}), 32'd0);
    check("reset/busy", 32'(busy_and), 32'd0);
    check("reset/done", 32'(done_and), 32'd0);
    check("reset/pass", 32'(pass_and), 32'd0);
    check("reset/err",  32'(err_and),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_run("and_model", 0, 1'b0);
    do_run("tied0",     1, 1'b0);
    do_run("tied1",     2, 1'b0);
    do_run("xor_model", 3, 1'b0);
    do_run("retrig",    0, 1'b1);
    do_run("tied1_b",   2, 1'b0);
    do_run("fresh_and", 0, 1'b0);
    reset_mid_run();
    do_run("post_rst",  0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
